// File: rtl/mmio_timer_core.sv
// 64-bit MMIO timer with a prescaler, compare match with optional auto-restart,
// W1C status flags, a level interrupt and coherent high-word snapshot reads.
module mmio_timer_core #(
   parameter int unsigned PRESC_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        irq
);

   localparam logic [4:0] A_CNT_LO = 5'd0;
   localparam logic [4:0] A_CNT_HI = 5'd1;
   localparam logic [4:0] A_CTRL   = 5'd2;
   localparam logic [4:0] A_CMP    = 5'd3;
   localparam logic [4:0] A_STATUS = 5'd4;
   localparam logic [4:0] A_CLEAR  = 5'd5;
   localparam logic [4:0] A_PRESC  = 5'd6;

   logic [63:0]        cnt_r;
   logic [63:0]        cnt_nxt_s;
   logic [PRESC_W-1:0] pcnt_r;
   logic [PRESC_W-1:0] pcnt_nxt_s;
   logic [PRESC_W-1:0] presc_r;
   logic [31:0]        hi_snap_r;
   logic [31:0]        cmp_r;
   logic [31:0]        rd_mux_s;
   logic               go_r;
   logic               periodic_r;
   logic               irq_en_r;
   logic               st_match_r;
   logic               st_ovf_r;

   logic rd_acc_s;
   logic wr_acc_s;
   logic clear_s;
   logic snap_s;
   logic tick_s;
   logic match_s;
   logic ovf_s;

   assign rd_acc_s = cs & read;
   assign wr_acc_s = cs & write;
   assign clear_s  = wr_acc_s & (addr == A_CLEAR);
   assign snap_s   = rd_acc_s & (addr == A_CNT_LO);
   assign tick_s   = go_r & (pcnt_r == presc_r);
   assign match_s  = tick_s & (cnt_r[31:0] == cmp_r);
   assign ovf_s    = tick_s & (cnt_r == {64{1'b1}});

   // Next count and prescaler phase; CLEAR outranks restart, restart outranks increment.
   always_comb begin
      cnt_nxt_s  = cnt_r;
      pcnt_nxt_s = pcnt_r;
      if (clear_s) begin
         cnt_nxt_s  = 64'd0;
         pcnt_nxt_s = {PRESC_W{1'b0}};
      end else begin
         if (match_s && periodic_r) begin
            cnt_nxt_s = 64'd0;
         end else if (tick_s) begin
            cnt_nxt_s = cnt_r + 64'd1;
         end else begin
            cnt_nxt_s = cnt_r;
         end
         if (tick_s) begin
            pcnt_nxt_s = {PRESC_W{1'b0}};
         end else if (go_r) begin
            pcnt_nxt_s = pcnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
         end else begin
            pcnt_nxt_s = pcnt_r;
         end
      end
   end

   // Counter, prescaler phase and the high-word snapshot taken on CNT_LO reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r     <= 64'd0;
         pcnt_r    <= {PRESC_W{1'b0}};
         hi_snap_r <= 32'd0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         pcnt_r <= pcnt_nxt_s;
         if (clear_s) begin
            hi_snap_r <= 32'd0;
         end else if (snap_s) begin
            hi_snap_r <= cnt_r[63:32];
         end
      end
   end

   // Software-writable configuration registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         go_r       <= 1'b0;
         periodic_r <= 1'b0;
         irq_en_r   <= 1'b0;
         cmp_r      <= 32'hFFFF_FFFF;
         presc_r    <= {PRESC_W{1'b0}};
      end else if (wr_acc_s) begin
         case (addr)
            A_CTRL: begin
               go_r       <= wr_data[0];
               periodic_r <= wr_data[1];
               irq_en_r   <= wr_data[2];
            end
            A_CMP:   cmp_r   <= wr_data;
            A_PRESC: presc_r <= wr_data[PRESC_W-1:0];
            default: ;
         endcase
      end
   end

   // Sticky status flags; a same-edge hardware set beats the W1C.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_match_r <= 1'b0;
         st_ovf_r   <= 1'b0;
      end else begin
         st_match_r <= match_s | (st_match_r & ~(wr_acc_s & (addr == A_STATUS) & wr_data[0]));
         st_ovf_r   <= ovf_s   | (st_ovf_r   & ~(wr_acc_s & (addr == A_STATUS) & wr_data[1]));
      end
   end

   // Read-data mux, driven only for a selected read outside reset.
   always_comb begin
      rd_mux_s = 32'd0;
      case (addr)
         A_CNT_LO: rd_mux_s = cnt_r[31:0];
         A_CNT_HI: rd_mux_s = hi_snap_r;
         A_CTRL:   rd_mux_s = {29'd0, irq_en_r, periodic_r, go_r};
         A_CMP:    rd_mux_s = cmp_r;
         A_STATUS: rd_mux_s = {30'd0, st_ovf_r, st_match_r};
         A_PRESC:  rd_mux_s = {{(32-PRESC_W){1'b0}}, presc_r};
         default:  rd_mux_s = 32'd0;
      endcase
      if (reset_n && rd_acc_s) begin
         rd_data = rd_mux_s;
      end else begin
         rd_data = 32'd0;
      end
   end

   assign irq = irq_en_r & st_match_r;

endmodule

// File: tb/tb_mmio_timer_core.sv
// Directed bench for mmio_timer_core: reads push expectations into a scoreboard,
// and a negedge monitor pops and compares rd_data/irq on every selected read.
module tb_mmio_timer_core;

   logic        clk;
   logic        reset_n;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_d_q[$];
   logic        exp_i_q[$];
   logic [4:0]  exp_a_q[$];
   logic [31:0] mon_d;
   logic        mon_i;
   logic [4:0]  mon_a;

   int per_tab[12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};

   mmio_timer_core #(.PRESC_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cs      (cs),
      .read    (read),
      .write   (write),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One bus cycle: inputs change 1 time unit after the edge, held until the next edge.
   task automatic drive(input logic c, input logic r, input logic w,
                        input logic [4:0] a, input logic [31:0] d);
      cs = c; read = r; write = w; addr = a; wr_data = d;
      @(posedge clk); #1;
      cs = 1'b0; read = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      drive(1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp_d, input logic exp_i);
      exp_d_q.push_back(exp_d);
      exp_i_q.push_back(exp_i);
      exp_a_q.push_back(a);
      drive(1'b1, 1'b1, 1'b0, a, 32'd0);
   endtask

   // Scoreboard monitor, sampling mid-cycle.
   always @(negedge clk) begin
      if (read) begin
         checks++;
         if (!cs) begin
            if (rd_data !== 32'd0) begin
               failures++;
               $display("FAIL stray_read addr=%0d got=%h want=00000000", addr, rd_data);
            end
         end else if (exp_d_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_read addr=%0d got=%h", addr, rd_data);
         end else begin
            mon_d = exp_d_q.pop_front();
            mon_i = exp_i_q.pop_front();
            mon_a = exp_a_q.pop_front();
            if (rd_data !== mon_d || irq !== mon_i || addr !== mon_a) begin
               failures++;
               $display("FAIL rd[%0d] got data=%h irq=%b addr=%0d want data=%h irq=%b addr=%0d",
                        mon_a, rd_data, irq, addr, mon_d, mon_i, mon_a);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      cs = 1'b0; read = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
      @(posedge clk); #1;
      rd(5'd3, 32'd0, 1'b0);
      idle(2);
      reset_n = 1'b1;

      for (int a = 0; a < 32; a++) begin
         rd(a[4:0], (a == 3) ? 32'hFFFF_FFFF : 32'd0, 1'b0);
      end

      // Free-running count with PRESC=0.
      wr(5'd6, 32'd0);
      wr(5'd2, 32'd1);
      idle(10);
      rd(5'd0, 32'd10, 1'b0);
      wr(5'd2, 32'd0);
      idle(3);
      rd(5'd0, 32'd12, 1'b0);
      rd(5'd2, 32'd0, 1'b0);

      // Coherent 64-bit read across a low-word carry.
      dut.cnt_r = 64'h0000_0001_FFFF_FFFF;
      rd(5'd0, 32'hFFFF_FFFF, 1'b0);
      wr(5'd2, 32'd1);
      idle(1);
      rd(5'd1, 32'h0000_0001, 1'b0);
      wr(5'd2, 32'd0);
      rd(5'd4, 32'd1, 1'b0);
      wr(5'd5, 32'd0);
      rd(5'd1, 32'd0, 1'b0);
      rd(5'd0, 32'd0, 1'b0);
      wr(5'd4, 32'd3);
      rd(5'd4, 32'd0, 1'b0);

      // Periodic match: CMP=4, PRESC=1 -> period 10 cycles.
      wr(5'd3, 32'd4);
      wr(5'd6, 32'd1);
      wr(5'd2, 32'd7);
      for (int k = 0; k < 12; k++) begin
         rd(5'd0, per_tab[k], (k >= 10));
      end
      wr(5'd4, 32'd1);
      rd(5'd4, 32'd0, 1'b0);
      idle(5);
      rd(5'd4, 32'd0, 1'b0);
      rd(5'd4, 32'd1, 1'b1);

      // W1C on the same edge as a match: set wins.
      idle(8);
      wr(5'd4, 32'd1);
      rd(5'd4, 32'd1, 1'b1);
      wr(5'd2, 32'd3);
      rd(5'd4, 32'd1, 1'b0);
      // CLEAR on a tick edge.
      wr(5'd5, 32'd0);
      rd(5'd0, 32'd0, 1'b0);
      rd(5'd0, 32'd0, 1'b0);
      rd(5'd0, 32'd1, 1'b0);
      rd(5'd2, 32'd3, 1'b0);

      // 64-bit wrap sets ovf.
      wr(5'd2, 32'd0);
      wr(5'd6, 32'd0);
      wr(5'd5, 32'd0);
      wr(5'd4, 32'd3);
      rd(5'd4, 32'd0, 1'b0);
      dut.cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
      wr(5'd2, 32'd1);
      rd(5'd0, 32'hFFFF_FFFF, 1'b0);
      rd(5'd4, 32'd2, 1'b0);
      rd(5'd1, 32'hFFFF_FFFF, 1'b0);
      wr(5'd2, 32'd0);
      rd(5'd0, 32'd3, 1'b0);
      rd(5'd1, 32'd0, 1'b0);

      // Unselected accesses have no effect.
      drive(1'b0, 1'b0, 1'b1, 5'd5, 32'd0);
      drive(1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
      drive(1'b0, 1'b1, 1'b0, 5'd3, 32'd0);
      rd(5'd0, 32'd3, 1'b0);
      rd(5'd2, 32'd0, 1'b0);
      rd(5'd6, 32'd0, 1'b0);

      idle(2);
      checks++;
      if (exp_d_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain pending=%0d want=0", exp_d_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_timer_core.md
# mmio_timer_core

Memory-mapped 64-bit free-running/periodic timer that answers on one MMIO slot. It receives the MMIO bus transactions that the I/O-to-MMIO bridge issues to its slot (chip select, read/write strobes, 5-bit register index, 32-bit data). It returns read data in the same cycle, because the bridge completes every transaction in one clock. It provides a 64-bit tick counter with coherent 64-bit reads, a prescaler, a compare match with optional auto-restart, sticky status flags and a level interrupt.

## Interface
- PRESC_W, 16: prescaler register width (bits).
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cs  input  1  slot select, from the slot decoder.
- read  input  1  read strobe, one cycle per transaction.
- write  input  1  write strobe, one cycle per transaction.
- addr  input  5  register index (word address within slot).
- wr_data  input  32  write data.
- rd_data  output  32  read data, combinational from registered state.
- irq  output  1  level interrupt, equal to CTRL.irq_en & STATUS.match.

## Operation
- Register map, by addr:
  - 0 CNT_LO (RO): cnt[31:0].
  - 1 CNT_HI (RO): hi_snap.
  - 2 CTRL (RW): bit0 go, bit1 periodic, bit2 irq_en; bits 31:3 read 0.
  - 3 CMP (RW): 32-bit compare value.
  - 4 STATUS (W1C): bit0 match, bit1 ovf.
  - 5 CLEAR (WO): any write clears the count; reads return 0.
  - 6 PRESC (RW): PRESC_W bits, zero-extended on read.
  - 7–31: read 0; writes are ignored.
- An access happens only when cs=1. read/write with cs=0 has no effect, and rd_data then returns 0.
- Coherent 64-bit read: a cs&read at CNT_LO loads hi_snap <= cnt[63:32] at that edge. Software reads CNT_LO, then CNT_HI.
- Prescaler: pcnt counts 0..PRESC while go=1. tick=1 when go & (pcnt==PRESC), and pcnt then wraps to 0. With PRESC=0, tick fires every cycle while go=1. Clearing go holds pcnt.
- Match event: tick & (cnt[31:0]==CMP).
- Counter update priority, highest first:
  - CLEAR write → cnt=0, pcnt=0, hi_snap=0.
  - match & periodic → cnt=0.
  - tick → cnt+1, modulo 2^64.
  - else hold.
- Periodic period is (CMP+1)*(PRESC+1) cycles.
- STATUS.match sets on a match event. STATUS.ovf sets when tick occurs with cnt=2^64-1 (wrap to 0).
- W1C: writing 1 to a STATUS bit clears it. If a set event and a W1C land on the same edge, set wins.
- Writes to CTRL, CMP and PRESC take effect at the write edge. A new CMP is used for comparison from the next cycle.

## Timing
- Reset (async assert, sync release by system) values: cnt=0, pcnt=0, hi_snap=0, CTRL=0, CMP=0xFFFF_FFFF, PRESC=0, STATUS=0, irq=0. rd_data=0 while reset_n=0.
- Read latency is zero: rd_data is valid in the cycle cs&read is high. The read's side effect (the hi_snap load) occurs at the closing edge.
- A write is visible on rd_data in the cycle after the write edge.
- The first tick occurs PRESC+1 cycles after go rises; cnt reads 1 on the cycle after that edge.
- irq asserts the cycle after the match edge, combinationally from the registered flag. It deasserts the cycle after the W1C edge or the irq_en clear edge.
- A reset mid-count returns all state to the reset values immediately; there is no pending-transaction memory, since every transaction is single-cycle.
- Back-to-back transactions on consecutive cycles are fully supported. There is no busy or ready state.

## Test plan
- Reset, then read all 32 addresses → 0 everywhere except CMP=0xFFFF_FFFF; irq=0.
- PRESC=0, CTRL=1 (go). Read CNT_LO exactly 10 cycles after the CTRL write edge → 10. Clear go → CNT_LO holds.
- Force cnt to 0x0000_0001_FFFF_FFFF via the backdoor. Read CNT_LO (0xFFFF_FFFF), then 3 cycles later read CNT_HI → 0x0000_0001, not 0x0000_0002.
- CMP=4, PRESC=1, CTRL=0b111 → match every 10 cycles; cnt sequence 0..4 then 0. irq rises 1 cycle after the first match edge. W1C STATUS=1 → irq drops; it rises again 10 cycles after the previous match.
- On the same edge, W1C STATUS.match and a new match → STATUS.match stays 1. On the same edge, CLEAR write and a tick → cnt=0.
- Backdoor cnt=2^64-1 with go → cnt=0 and STATUS.ovf=1. Accesses with cs=0 to CLEAR and CTRL → no state change, and rd_data=0.
